register_file_2r1w: RTL and testbench

- Parametrised multi-bit successor to the single-bit D storage element: DEPTH words × WIDTH bits of clocked storage.
- One synchronous write port and two combinational read ports; synchronous clear of all words.
- Serves as the CPU general-purpose register bank, feeding both ALU operands and taking the writeback result.

---
 rtl/register_file_2r1w.sv | 90 +++++++++
 tb/tb_register_file_2r1w.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/register_file_2r1w.sv
// register_file_2r1w
//   DEPTH x WIDTH general-purpose register bank: one synchronous write port,
//   two combinational read ports, synchronous clear of every word.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   -> write-through forwarding: a read port addressing the word
//                  being written this cycle returns inWrData combinationally.
//     undefined -> no forwarding; the new value appears the cycle after the
//                  write edge.
//
// Parameters
//   WIDTH    bits per word
//   DEPTH    number of words (power of two, >= 2)
//   ADDR_W   address width, log2(DEPTH)
//   ZERO_REG 1 = register 0 reads as zero and ignores writes
//
// Ports
//   inClk       clock, rising edge
//   inClr       synchronous active-high clear of all words and outWrAck
//   inWrEn      write enable
//   inWrAddr    write address
//   inWrData    write data
//   inRdAddrA   read port A address
//   inRdAddrB   read port B address
//   outRdDataA  read port A data (combinational)
//   outRdDataB  read port B data (combinational)
//   outWrAck    registered, high one cycle after an accepted write
module register_file_2r1w #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              inClk,
  input  logic              inClr,
  input  logic              inWrEn,
  input  logic [ADDR_W-1:0] inWrAddr,
  input  logic [WIDTH-1:0]  inWrData,
  input  logic [ADDR_W-1:0] inRdAddrA,
  input  logic [ADDR_W-1:0] inRdAddrB,
  output logic [WIDTH-1:0]  outRdDataA,
  output logic [WIDTH-1:0]  outRdDataB,
  output logic              outWrAck
);

  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;

  // A write is accepted unless clear wins or it targets a hardwired zero reg.
  always_comb begin
    wr_ok = inWrEn & ~inClr & ~(ZERO_EN & (inWrAddr == '0));
  end

  always_ff @(posedge inClk) begin
    if (inClr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      outWrAck <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[inWrAddr] <= inWrData;
      end
      outWrAck <= wr_ok;
    end
  end

  always_comb begin
    outRdDataA = mem[inRdAddrA];
    outRdDataB = mem[inRdAddrB];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (inRdAddrA == inWrAddr)) begin
      outRdDataA = inWrData;
    end
    if (wr_ok && (inRdAddrB == inWrAddr)) begin
      outRdDataB = inWrData;
    end
`endif
    // Zero-register masking applied last so it overrides forwarding too.
    if (ZERO_EN && (inRdAddrA == '0)) begin
      outRdDataA = '0;
    end
    if (ZERO_EN && (inRdAddrB == '0)) begin
      outRdDataB = '0;
    end
  end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Testbench for register_file_2r1w: two instances (ZERO_REG=1 and ZERO_REG=0)
// share one stimulus stream; a behavioural array model predicts both.
module tb_register_file_2r1w;

  logic        inClk = 1'b0;
  logic        inClr;
  logic        inWrEn;
  logic [3:0]  inWrAddr;
  logic [15:0] inWrData;
  logic [3:0]  inRdAddrA;
  logic [3:0]  inRdAddrB;
  logic [15:0] rd_a1, rd_b1, rd_a0, rd_b0;
  logic        ack1, ack0;

  int checks = 0;
  int errors = 0;

  // model state: index 1 -> ZERO_REG=1 instance, index 0 -> ZERO_REG=0
  logic [15:0] m1 [16];
  logic [15:0] m0 [16];
  logic        e_ack1, e_ack0;

  always #5 inClk = ~inClk;

  register_file_2r1w #(.WIDTH(16), .DEPTH(16), .ADDR_W(4), .ZERO_REG(1)) dut1 (
    .inClk(inClk), .inClr(inClr), .inWrEn(inWrEn), .inWrAddr(inWrAddr),
    .inWrData(inWrData), .inRdAddrA(inRdAddrA), .inRdAddrB(inRdAddrB),
    .outRdDataA(rd_a1), .outRdDataB(rd_b1), .outWrAck(ack1)
  );

  register_file_2r1w #(.WIDTH(16), .DEPTH(16), .ADDR_W(4), .ZERO_REG(0)) dut0 (
    .inClk(inClk), .inClr(inClr), .inWrEn(inWrEn), .inWrAddr(inWrAddr),
    .inWrData(inWrData), .inRdAddrA(inRdAddrA), .inRdAddrB(inRdAddrB),
    .outRdDataA(rd_a0), .outRdDataB(rd_b0), .outWrAck(ack0)
  );

  function automatic bit accepted(input bit zr);
    return inWrEn && !inClr && !(zr && inWrAddr == 4'd0);
  endfunction

  function automatic logic [15:0] exp_rd(input bit zr, input logic [3:0] a);
    if (zr && a == 4'd0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (accepted(zr) && a == inWrAddr) return inWrData;
`endif
    return zr ? m1[a] : m0[a];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " rdA z1"}, rd_a1, exp_rd(1'b1, inRdAddrA));
    chk({tag, " rdB z1"}, rd_b1, exp_rd(1'b1, inRdAddrB));
    chk({tag, " rdA z0"}, rd_a0, exp_rd(1'b0, inRdAddrA));
    chk({tag, " rdB z0"}, rd_b0, exp_rd(1'b0, inRdAddrB));
    chk({tag, " ack z1"}, {15'd0, ack1}, {15'd0, e_ack1});
    chk({tag, " ack z0"}, {15'd0, ack0}, {15'd0, e_ack0});
  endtask

  // One rising edge: model absorbs the inputs present at the edge.
  task automatic tick();
    bit a1, a0;
    @(posedge inClk);
    a1 = accepted(1'b1);
    a0 = accepted(1'b0);
    if (inClr) begin
      for (int i = 0; i < 16; i++) begin
        m1[i] = 16'h0000;
        m0[i] = 16'h0000;
      end
    end else begin
      if (a1) m1[inWrAddr] = inWrData;
      if (a0) m0[inWrAddr] = inWrData;
    end
    e_ack1 = a1;
    e_ack0 = a0;
    #1;
  endtask

  task automatic set_in(input bit clr, input bit en, input logic [3:0] wa,
                        input logic [15:0] wd, input logic [3:0] ra, input logic [3:0] rb);
    inClr = clr; inWrEn = en; inWrAddr = wa; inWrData = wd;
    inRdAddrA = ra; inRdAddrB = rb;
    #1;
  endtask

  initial begin
    set_in(1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
    tick();

    // 1: all words zero after reset, ack low
    for (int i = 0; i < 16; i++) begin
      set_in(1'b0, 1'b0, 4'd0, 16'h0, 4'(i), 4'(15 - i));
      chk("reset rdA", rd_a0, 16'h0000);
      chk("reset rdB", rd_b1, 16'h0000);
      check_all("reset");
      tick();
    end

    // 2: write BEEF to r5, ack exactly one cycle
    set_in(1'b0, 1'b1, 4'd5, 16'hBEEF, 4'd1, 4'd2);
    tick();
    set_in(1'b0, 1'b0, 4'd5, 16'h0, 4'd5, 4'd5);
    chk("r5 direct", rd_a1, 16'hBEEF);
    chk("ack after write", {15'd0, ack1}, 16'h0001);
    check_all("r5");
    tick();
    chk("ack one cycle", {15'd0, ack1}, 16'h0000);
    check_all("r5 hold");

    // 3: write to r0
    set_in(1'b0, 1'b1, 4'd0, 16'h1234, 4'd3, 4'd4);
    tick();
    set_in(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
    chk("r0 zero", rd_a1, 16'h0000);
    chk("r0 plain", rd_a0, 16'h1234);
    chk("r0 ack z1", {15'd0, ack1}, 16'h0000);
    chk("r0 ack z0", {15'd0, ack0}, 16'h0001);
    check_all("r0");
    tick();

    // 4: clear beats write
    set_in(1'b1, 1'b1, 4'd3, 16'hAAAA, 4'd3, 4'd5);
    tick();
    set_in(1'b0, 1'b0, 4'd0, 16'h0, 4'd3, 4'd5);
    chk("clr r3", rd_a1, 16'h0000);
    chk("clr r5", rd_b1, 16'h0000);
    chk("clr ack", {15'd0, ack0}, 16'h0000);
    check_all("clr");
    tick();

    // 5: same-cycle read of register being written
    set_in(1'b0, 1'b1, 4'd7, 16'h0001, 4'd0, 4'd0);
    tick();
    set_in(1'b0, 1'b1, 4'd7, 16'h0002, 4'd7, 4'd6);
`ifdef REGFILE_BYPASS_EN
    chk("bypass in-cycle", rd_a1, 16'h0002);
`else
    chk("no bypass in-cycle", rd_a1, 16'h0001);
`endif
    check_all("wr r7");
    tick();
    set_in(1'b0, 1'b0, 4'd0, 16'h0, 4'd7, 4'd7);
    chk("r7 after", rd_b0, 16'h0002);
    check_all("r7 after");
    tick();

    // 6: back-to-back writes, ack high three cycles
    set_in(1'b0, 1'b1, 4'd1, 16'h0011, 4'd1, 4'd2);
    tick();
    set_in(1'b0, 1'b1, 4'd2, 16'h0022, 4'd1, 4'd2);
    chk("b2b ack1", {15'd0, ack1}, 16'h0001);
    check_all("b2b 1");
    tick();
    set_in(1'b0, 1'b1, 4'd1, 16'h0033, 4'd1, 4'd2);
    chk("b2b ack2", {15'd0, ack1}, 16'h0001);
    check_all("b2b 2");
    tick();
    set_in(1'b0, 1'b0, 4'd0, 16'h0, 4'd1, 4'd2);
    chk("b2b ack3", {15'd0, ack1}, 16'h0001);
    chk("b2b r1", rd_a1, 16'h0033);
    chk("b2b r2", rd_b1, 16'h0022);
    check_all("b2b 3");
    tick();
    chk("b2b ack end", {15'd0, ack1}, 16'h0000);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      set_in(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
             4'($urandom_range(0, 15)), 16'($urandom),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      check_all("rand");
      tick();
    end
    set_in(1'b0, 1'b0, 4'd0, 16'h0, 4'd9, 4'd0);
    check_all("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
